// File: rtl/rvx_branch_predictor.sv
// rvx_branch_predictor
//   Direct-mapped branch target buffer with per-entry saturating counters.
//   Fetch side looks up if_pc combinationally; execute side trains the table
//   with resolved control transfers and raises a redirect on mispredicts.
//   A clr_req pulse starts a one-entry-per-cycle invalidation sweep.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   if_pc -> pred_taken, pred_target  fetch lookup
//   ex_valid, ex_pc, ex_target,
//   ex_taken, ex_pred_taken,
//   ex_pred_target -> ex_mispredict   execute-stage resolution / training
//   clr_req -> busy                   table invalidation sweep
//   stat_lookups/updates/mispredicts  performance counters
//
// Configuration
//   RVX_BP_STATS_EN  defined: performance counters implemented;
//                    undefined: stat_* tied to zero, no counter flops.
module rvx_branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_taken,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_mispredict,
  input  logic            clr_req,
  output logic            busy,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
);
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(2 ** (CTR_BITS - 1));

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  state_e              state_q;
  logic                busy_q;
  idx_t                sweep_q;
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [XLEN-1:0]     tgt_q [ENTRIES];

  idx_t                if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                if_hit, ex_hit, upd_ok;
  logic [CTR_BITS-1:0] ctr_d;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[TAG_LO+TAG_BITS-1:TAG_LO];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[TAG_LO+TAG_BITS-1:TAG_LO];

  // PC bits outside index/tag never participate in training.
  logic unused_ex_pc;
  assign unused_ex_pc = ^{ex_pc[1:0], ex_pc[XLEN-1:TAG_LO+TAG_BITS]};

  // Lookup reads pre-update contents: no write-to-read bypass.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][CTR_BITS-1] && !busy_q;
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(4);

  assign ex_mispredict = ex_valid && ((ex_pred_taken != ex_taken) ||
                                      (ex_taken && (ex_pred_target != ex_target)));

  // Training is dropped in the clr_req cycle and for the whole sweep.
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd_ok = ex_valid && (state_q == S_IDLE) && !clr_req;
  assign busy   = busy_q;

  always_comb begin
    ctr_d = ctr_q[ex_idx];
    if (ex_taken && (ctr_q[ex_idx] != '1))       ctr_d = ctr_q[ex_idx] + CTR_BITS'(1);
    else if (!ex_taken && (ctr_q[ex_idx] != '0)) ctr_d = ctr_q[ex_idx] - CTR_BITS'(1);
  end

  // Payload arrays: no reset, qualified by valid_q.
  always_ff @(posedge clk) begin
    if (upd_ok) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_d;
        if (ex_taken) tgt_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        tag_q[ex_idx] <= ex_tag;
        ctr_q[ex_idx] <= CTR_WEAK;
        tgt_q[ex_idx] <= ex_target;
      end
    end
  end

  // Control FSM plus valid bits. busy_q mirrors SWEEP so it is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      sweep_q <= '0;
      valid_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr_req) begin
            state_q <= S_SWEEP;
            busy_q  <= 1'b1;
            sweep_q <= '0;
          end else if (upd_ok && !ex_hit && ex_taken) begin
            valid_q[ex_idx] <= 1'b1;
          end
        end
        S_SWEEP: begin
          valid_q[sweep_q] <= 1'b0;
          sweep_q          <= sweep_q + idx_t'(1);
          if (sweep_q == idx_t'(ENTRIES - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RVX_BP_STATS_EN
  logic [31:0] lk_q, up_q, mp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_q <= '0;
      up_q <= '0;
      mp_q <= '0;
    end else begin
      if (!busy_q)       lk_q <= lk_q + 32'd1;
      if (upd_ok)        up_q <= up_q + 32'd1;
      if (ex_mispredict) mp_q <= mp_q + 32'd1;
    end
  end

  assign stat_lookups     = lk_q;
  assign stat_updates     = up_q;
  assign stat_mispredicts = mp_q;
`else
  assign stat_lookups     = 32'd0;
  assign stat_updates     = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_rvx_branch_predictor.sv
// Self-checking bench for rvx_branch_predictor: directed scenarios followed
// by randomized traffic, all compared against a table-level reference model.
module tb_rvx_branch_predictor;
  localparam int XLEN     = 32;
  localparam int ENTRIES  = 64;
  localparam int CTR_BITS = 2;
  localparam int TAG_BITS = 8;
`ifdef RVX_BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [XLEN-1:0] if_pc = '0;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid = 1'b0;
  logic [XLEN-1:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic            ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic            ex_mispredict;
  logic            clr_req = 1'b0;
  logic            busy;
  logic [31:0]     stat_lookups, stat_updates, stat_mispredicts;

  rvx_branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS),
                         .TAG_BITS(TAG_BITS)) dut (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_mispredict(ex_mispredict),
    .clr_req(clr_req), .busy(busy), .stat_lookups(stat_lookups),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Reference model: per-entry record plus a busy-cycle countdown.
  bit          m_v   [ENTRIES];
  int unsigned m_tag [ENTRIES];
  int          m_ctr [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          busy_cnt;
  logic [31:0] m_lk, m_up, m_mp;

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned mtag(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (2 ** TAG_BITS);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_v[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[midx(pc)] >= 2 ** (CTR_BITS - 1)) && (busy_cnt == 0);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pred(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
    busy_cnt = 0;
    m_lk = 0; m_up = 0; m_mp = 0;
  endtask

  task automatic m_edge();
    bit mis, acc;
    int i;
    mis = ex_valid && ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target));
    acc = ex_valid && (busy_cnt == 0) && !clr_req;
    if (busy_cnt == 0) m_lk++;
    if (acc) m_up++;
    if (mis) m_mp++;
    i = midx(ex_pc);
    if (acc) begin
      if (m_hit(ex_pc)) begin
        m_ctr[i] = ex_taken ? ((m_ctr[i] < 2 ** CTR_BITS - 1) ? m_ctr[i] + 1 : m_ctr[i])
                            : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (ex_taken) m_tgt[i] = ex_target;
      end else if (ex_taken) begin
        m_v[i] = 1'b1; m_tag[i] = mtag(ex_pc);
        m_ctr[i] = 2 ** (CTR_BITS - 1); m_tgt[i] = ex_target;
      end
    end
    // Observable effect of a sweep: table dead for ENTRIES cycles, then empty.
    if (busy_cnt > 0) busy_cnt--;
    else if (clr_req) begin
      busy_cnt = ENTRIES;
      for (int k = 0; k < ENTRIES; k++) m_v[k] = 1'b0;
    end
  endtask

  task automatic check_outs();
    chk("pred_taken",  {31'd0, pred_taken}, {31'd0, m_pred(if_pc)});
    chk("pred_target", pred_target, m_ptgt(if_pc));
    chk("ex_mispredict", {31'd0, ex_mispredict},
        {31'd0, ex_valid && ((ex_pred_taken != ex_taken) ||
                             (ex_taken && ex_pred_target != ex_target))});
    chk("busy", {31'd0, busy}, {31'd0, busy_cnt > 0});
    chk("stat_lookups",     stat_lookups,     STATS ? m_lk : 32'd0);
    chk("stat_updates",     stat_updates,     STATS ? m_up : 32'd0);
    chk("stat_mispredicts", stat_mispredicts, STATS ? m_mp : 32'd0);
  endtask

  // One cycle: drive after negedge, check mid-cycle, advance model at posedge.
  task automatic drive(input logic [31:0] ipc, input logic ev, input logic [31:0] epc,
                       input logic tk, input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ptgt, input logic clr);
    @(negedge clk);
    if_pc = ipc; ex_valid = ev; ex_pc = epc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt; clr_req = clr;
    #1;
    check_outs();
    @(posedge clk);
    m_edge();
  endtask

  task automatic idle(input logic [31:0] ipc);
    drive(ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ex_valid = 1'b0; clr_req = 1'b0; if_pc = 32'h100;
    reset_n = 1'b0;
    m_clear();
    #1;
    check_outs();
    chk("rst_pred_target", pred_target, 32'h104);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 7))
      0: return 32'h100;
      1: return 32'h104;
      2: return 32'h200;
      3: return 32'h100 + 4 * ENTRIES;
      4: return 32'h300;
      5: return 32'h1000 + ($urandom_range(0, 15) << 2);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] p, t, pt;
    logic ptk;
    m_clear();
    do_reset();

    // Allocate 0x100 with a mispredict, then lookup hits.
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    idle(32'h100);
    chk("alloc_pred_target", pred_target, 32'h40);
    // Alias with same index but different tag must miss.
    idle(32'h100 + 4 * ENTRIES);
    // Three not-taken updates: counter walks down and saturates.
    repeat (3) begin
      drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
      idle(32'h100);
    end
    chk("sat_pred_taken", {31'd0, pred_taken}, 32'd0);
    // Two taken updates restore prediction with a new target.
    repeat (2) drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    idle(32'h100);

    // Sweep: busy for ENTRIES cycles, an update at cycle 10 is dropped.
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int c = 1; c <= ENTRIES; c++) begin
      if (c == 10) drive(32'h300, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
      else if (c == 20) drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      else idle(32'h100);
    end
    idle(32'h100);
    idle(32'h300);

    // Same-cycle allocate and lookup of 0x200 from a clean reset.
    do_reset();
    drive(32'h200, 1'b1, 32'h200, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
    idle(32'h200);
    chk("same_cycle_next", {31'd0, pred_taken}, 32'd1);

    // Reset in the middle of a sweep aborts it and leaves the table empty.
    drive(32'h104, 1'b1, 32'h104, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0);
    drive(32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    repeat (20) idle(32'h104);
    do_reset();
    idle(32'h104);
    idle(32'h200);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      p   = pick_pc();
      ptk = $urandom_range(0, 1) ? m_pred(p) : 1'($urandom);
      pt  = $urandom_range(0, 1) ? m_ptgt(p) : $urandom;
      t   = $urandom_range(0, 3) != 0 ? (32'h2000 + ($urandom_range(0, 7) << 2)) : $urandom;
      drive(pick_pc(), $urandom_range(0, 9) < 7, p, 1'($urandom), t, ptk, pt,
            $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
